// File: rtl/axil_regbank_pkg.sv
// Shared response codes and address/strobe helpers for the AXI4-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index from a byte address; the caller zero-extends the address to 32 bits.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regbank_wjoin.sv
// Joins independently accepted AW and W beats into one write commit strobe.
module axil_regbank_wjoin
  import axil_regbank_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  input  logic              bvalid,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [31:0]       commit_data,
  output logic [3:0]        commit_strb
);

  logic              aw_held_r;
  logic              w_held_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;

  assign awready     = aresetn & ~aw_held_r & ~bvalid;
  assign wready      = aresetn & ~w_held_r & ~bvalid;
  assign commit      = aw_held_r & w_held_r;
  assign commit_addr = awaddr_r;
  assign commit_data = wdata_r;
  assign commit_strb = wstrb_r;

  // Capture each channel on its own handshake; both flags drop on the commit edge.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awaddr_r  <= {ADDR_W{1'b0}};
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
    end else if (commit) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held_r <= 1'b1;
        awaddr_r  <= awaddr;
      end
      if (wvalid && wready) begin
        w_held_r <= 1'b1;
        wdata_r  <= wdata;
        wstrb_r  <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank: NOUT read/write registers followed by
// read-only fabric inputs, with per-register write/read strobe pulses.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int NOUT   = 3,
  parameter int ADDR_W = 8
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_aresetn,
  output logic [NOUT*32-1:0]       oregs,
  input  logic [(NREG-NOUT)*32-1:0] iregs,
  output logic [NREG-1:0]          wr_pulse,
  output logic [NREG-1:0]          rd_pulse,
  input  logic [ADDR_W-1:0]        s00_axi_awaddr,
  input  logic [2:0]               s00_axi_awprot,
  input  logic                     s00_axi_awvalid,
  output logic                     s00_axi_awready,
  input  logic [31:0]              s00_axi_wdata,
  input  logic [3:0]               s00_axi_wstrb,
  input  logic                     s00_axi_wvalid,
  output logic                     s00_axi_wready,
  output logic [1:0]               s00_axi_bresp,
  output logic                     s00_axi_bvalid,
  input  logic                     s00_axi_bready,
  input  logic [ADDR_W-1:0]        s00_axi_araddr,
  input  logic [2:0]               s00_axi_arprot,
  input  logic                     s00_axi_arvalid,
  output logic                     s00_axi_arready,
  output logic [31:0]              s00_axi_rdata,
  output logic [1:0]               s00_axi_rresp,
  output logic                     s00_axi_rvalid,
  input  logic                     s00_axi_rready
);

  logic [31:0]       oregs_r [NOUT];
  logic [NREG-1:0]   wr_pulse_r;
  logic [NREG-1:0]   rd_pulse_r;
  logic              bvalid_r;
  logic [1:0]        bresp_r;
  logic              rvalid_r;
  logic [1:0]        rresp_r;
  logic [31:0]       rdata_r;
  logic              commit_s;
  logic [ADDR_W-1:0] commit_addr_s;
  logic [31:0]       commit_data_s;
  logic [3:0]        commit_strb_s;
  logic [31:0]       widx_s;
  logic [31:0]       ridx_s;
  logic [31:0]       rd_mux_s;
  logic              ar_hs_s;
  logic              unused_prot_s;

  axil_regbank_wjoin #(.ADDR_W(ADDR_W)) u_wjoin (
    .clk         (s00_axi_aclk),
    .aresetn     (s00_axi_aresetn),
    .awaddr      (s00_axi_awaddr),
    .awvalid     (s00_axi_awvalid),
    .awready     (s00_axi_awready),
    .wdata       (s00_axi_wdata),
    .wstrb       (s00_axi_wstrb),
    .wvalid      (s00_axi_wvalid),
    .wready      (s00_axi_wready),
    .bvalid      (bvalid_r),
    .commit      (commit_s),
    .commit_addr (commit_addr_s),
    .commit_data (commit_data_s),
    .commit_strb (commit_strb_s)
  );

  // Protection bits carry no meaning for this bank.
  assign unused_prot_s = ^{s00_axi_awprot, s00_axi_arprot};

  assign widx_s          = addr_to_idx(32'(commit_addr_s));
  assign ridx_s          = addr_to_idx(32'(s00_axi_araddr));
  assign s00_axi_arready = s00_axi_aresetn & ~rvalid_r;
  assign ar_hs_s         = s00_axi_arvalid & s00_axi_arready;

  // Read mux uses the pre-commit register value; unmapped indices read as zero.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    for (int i = 0; i < NOUT; i++) begin
      rd_mux_s = (ridx_s == 32'(i)) ? oregs_r[i] : rd_mux_s;
    end
    for (int j = 0; j < NREG - NOUT; j++) begin
      rd_mux_s = (ridx_s == 32'(NOUT + j)) ? iregs[32*j +: 32] : rd_mux_s;
    end
  end

  // Write commit: byte-merge into RW registers, pulse, and raise the B response.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NOUT; i++) begin
        oregs_r[i] <= 32'h0000_0000;
      end
      wr_pulse_r <= {NREG{1'b0}};
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        wr_pulse_r[i] <= commit_s && (widx_s == 32'(i)) && (i < NOUT);
      end
      for (int i = 0; i < NOUT; i++) begin
        if (commit_s && (widx_s == 32'(i))) begin
          oregs_r[i] <= strb_merge(oregs_r[i], commit_data_s, commit_strb_s);
        end
      end
      if (commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (widx_s < 32'(NOUT)) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_r && s00_axi_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read capture on the AR handshake, held until the master takes it.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= 32'h0000_0000;
      rd_pulse_r <= {NREG{1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rd_pulse_r[i] <= ar_hs_s && (ridx_s == 32'(i));
      end
      if (ar_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_mux_s;
        rresp_r  <= (ridx_s < 32'(NREG)) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_r && s00_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_oregs
    assign oregs[32*g +: 32] = oregs_r[g];
  end

  assign wr_pulse       = wr_pulse_r;
  assign rd_pulse       = rd_pulse_r;
  assign s00_axi_bvalid = bvalid_r;
  assign s00_axi_bresp  = bresp_r;
  assign s00_axi_rvalid = rvalid_r;
  assign s00_axi_rresp  = rresp_r;
  assign s00_axi_rdata  = rdata_r;

endmodule

// File: tb/tb_axil_regbank.sv
// Directed vector bench for axil_regbank (NREG=8, NOUT=3, ADDR_W=8).
module tb_axil_regbank;

  localparam int NREG   = 8;
  localparam int NOUT   = 3;
  localparam int ADDR_W = 8;
  localparam int NV     = 14;

  logic                      clk = 1'b0;
  logic                      aresetn;
  logic [NOUT*32-1:0]        oregs;
  logic [(NREG-NOUT)*32-1:0] iregs;
  logic [NREG-1:0]           wr_pulse, rd_pulse;
  logic [ADDR_W-1:0]         awaddr, araddr;
  logic [2:0]                awprot, arprot;
  logic                      awvalid, awready, wvalid, wready, bvalid, bready;
  logic                      arvalid, arready, rvalid, rready;
  logic [31:0]               wdata, rdata;
  logic [3:0]                wstrb;
  logic [1:0]                bresp, rresp;

  axil_regbank #(.NREG(NREG), .NOUT(NOUT), .ADDR_W(ADDR_W)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .oregs(oregs), .iregs(iregs), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t tbl [NV];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [7:0] pulse);
    logic aw_done, w_done, got_b, aw_hs, w_hs;
    aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0; resp = 2'b11; pulse = 8'h00;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int k = 0; k < 16 && !(aw_done && w_done); k++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    for (int k = 0; k < 16 && !got_b; k++) begin
      if (bvalid) begin got_b = 1'b1; resp = bresp; pulse = wr_pulse; end
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check("write_bvalid_seen", {31'b0, got_b}, 32'h1);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic [7:0] pulse);
    logic ar_done, got_r, ar_hs;
    ar_done = 1'b0; got_r = 1'b0; d = 32'hxxxx_xxxx; resp = 2'b11; pulse = 8'h00;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int k = 0; k < 16 && !ar_done; k++) begin
      ar_hs = arvalid && arready;
      step();
      if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
    end
    for (int k = 0; k < 16 && !got_r; k++) begin
      if (rvalid) begin got_r = 1'b1; d = rdata; resp = rresp; pulse = rd_pulse; end
      step();
    end
    arvalid = 1'b0; rready = 1'b0;
    check("read_rvalid_seen", {31'b0, got_r}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic        stable;

    tbl[0]  = '{1'b0, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 8'h02};
    tbl[1]  = '{1'b1, 8'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 8'h02};
    tbl[2]  = '{1'b0, 8'h00, 32'h11223344, 4'hF, 32'h0,        2'b00, 8'h01};
    tbl[3]  = '{1'b0, 8'h00, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00, 8'h01};
    tbl[4]  = '{1'b1, 8'h00, 32'h0,        4'h0, 32'h11BB33DD, 2'b00, 8'h01};
    tbl[5]  = '{1'b0, 8'h10, 32'h12345678, 4'hF, 32'h0,        2'b10, 8'h00};
    tbl[6]  = '{1'b1, 8'h10, 32'h0,        4'h0, 32'h44440004, 2'b00, 8'h10};
    tbl[7]  = '{1'b1, 8'h20, 32'h0,        4'h0, 32'h00000000, 2'b10, 8'h00};
    tbl[8]  = '{1'b1, 8'h07, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 8'h02};
    tbl[9]  = '{1'b0, 8'h0B, 32'h000000A5, 4'h1, 32'h0,        2'b00, 8'h04};
    tbl[10] = '{1'b1, 8'h08, 32'h0,        4'h0, 32'h000000A5, 2'b00, 8'h04};
    tbl[11] = '{1'b0, 8'hFC, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 8'h00};
    tbl[12] = '{1'b1, 8'h1C, 32'h0,        4'h0, 32'h77770007, 2'b00, 8'h80};
    tbl[13] = '{1'b1, 8'h0C, 32'h0,        4'h0, 32'h33330003, 2'b00, 8'h08};

    iregs = {32'h77770007, 32'h66660006, 32'hCAFE0005, 32'h44440004, 32'h33330003};
    awaddr = 8'h00; araddr = 8'h00; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = 32'h0; wstrb = 4'h0;

    // Power-on reset
    aresetn = 1'b0;
    repeat (3) step();
    check("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
    check("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
    check("rst_oregs0", oregs[31:0], 32'h0);
    aresetn = 1'b1;
    step();
    check("post_rst_ready", {29'b0, awready, wready, arready}, 32'h7);

    // Table-driven transactions
    for (int v = 0; v < NV; v++) begin
      if (tbl[v].is_rd) begin
        axi_read(tbl[v].addr, rd, resp, pulse);
        check($sformatf("v%0d_rdata", v), rd, tbl[v].exp_rdata);
      end else begin
        axi_write(tbl[v].addr, tbl[v].data, tbl[v].strb, resp, pulse);
      end
      check($sformatf("v%0d_resp", v), {30'b0, resp}, {30'b0, tbl[v].exp_resp});
      check($sformatf("v%0d_pulse", v), {24'b0, pulse}, {24'b0, tbl[v].exp_pulse});
    end
    check("oregs0", oregs[31:0],  32'h11BB33DD);
    check("oregs1", oregs[63:32], 32'hDEADBEEF);
    check("oregs2", oregs[95:64], 32'h000000A5);

    // Reset landing on the commit edge of a write, then held three edges
    awaddr = 8'h04; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; aresetn = 1'b0;
    step();
    check("midrst_bvalid", {31'b0, bvalid}, 32'h0);
    check("midrst_pulse", {24'b0, wr_pulse}, 32'h0);
    check("midrst_ready", {29'b0, awready, wready, arready}, 32'h0);
    repeat (2) step();
    check("midrst_oregs1", oregs[63:32], 32'h0);
    check("midrst_oregs0", oregs[31:0], 32'h0);
    aresetn = 1'b1;
    step();
    check("midrst_ready_after", {29'b0, awready, wready, arready}, 32'h7);
    step();
    check("midrst_no_late_commit", {31'b0, bvalid}, 32'h0);
    check("midrst_oregs1_after", oregs[63:32], 32'h0);

    // W leads AW by three cycles; B held off for four cycles
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    check("wfirst_wready", {31'b0, wready}, 32'h1);
    step();
    wvalid = 1'b0;
    stable = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (wready !== 1'b0) stable = 1'b0;
      if (c < 3) step();
    end
    check("wfirst_wready_low", {31'b0, stable}, 32'h1);
    awaddr = 8'h08; awvalid = 1'b1;
    check("wfirst_awready", {31'b0, awready}, 32'h1);
    step();
    awvalid = 1'b0;
    check("wfirst_no_early_b", {31'b0, bvalid}, 32'h0);
    step();
    check("wfirst_bvalid", {31'b0, bvalid}, 32'h1);
    check("wfirst_bresp", {30'b0, bresp}, 32'h0);
    check("wfirst_pulse", {24'b0, wr_pulse}, 32'h04);
    check("wfirst_oregs2", oregs[95:64], 32'h5);
    stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 ||
          wr_pulse !== 8'h00) stable = 1'b0;
    end
    check("wfirst_b_held", {31'b0, stable}, 32'h1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("wfirst_b_cleared", {31'b0, bvalid}, 32'h0);
    check("wfirst_ready_back", {30'b0, awready, wready}, 32'h3);

    // Read of RO idx 5 with R held off for four cycles
    araddr = 8'h14; arvalid = 1'b1; rready = 1'b0;
    check("rhold_arready", {31'b0, arready}, 32'h1);
    step();
    arvalid = 1'b0;
    check("rhold_rvalid", {31'b0, rvalid}, 32'h1);
    check("rhold_rdata", rdata, 32'hCAFE0005);
    check("rhold_rresp", {30'b0, rresp}, 32'h0);
    check("rhold_pulse", {24'b0, rd_pulse}, 32'h20);
    stable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE0005 || arready !== 1'b0 ||
          rd_pulse !== 8'h00) stable = 1'b0;
    end
    check("rhold_stable", {31'b0, stable}, 32'h1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rhold_cleared", {31'b0, rvalid}, 32'h0);
    check("rhold_arready_back", {31'b0, arready}, 32'h1);

    // AR on the same edge as a write commit to the same register sees the old value
    awaddr = 8'h00; wdata = 32'h0000BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; araddr = 8'h00; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check("race_rdata_old", rdata, 32'h0);
    check("race_oregs0_new", oregs[31:0], 32'h0000BEEF);
    check("race_pulses", {16'b0, wr_pulse, rd_pulse}, 32'h0101);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check("race_cleared", {30'b0, bvalid, rvalid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
